popcnt_stream: RTL and testbench

- Sequential, parametrised successor to the team's 3-input ones-counter cell (majority plus XOR outputs).
- Takes WIDTH-bit words over a valid/ready handshake and counts their set bits, CHUNK bits per cycle.
- Returns the count, parity and majority flag over a second valid/ready handshake.
- Keeps a saturating running total across words when accumulate mode is on.
- Sits between a word source and the statistics/decision logic.

---
 rtl/popcnt_stream.sv | 146 ++++++++++++++
 tb/tb_popcnt_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_stream.sv
// Streaming popcount: counts set bits of a WIDTH-bit word CHUNK bits per cycle and
// returns count, parity, majority and a saturating running total over valid/ready.
//
// state | meaning
// IDLE  | ready for a new word (in_ready=1 once out of reset)
// BUSY  | consuming CHUNK bits per cycle, LSB-first, for N cycles
// DONE  | result held on the outputs until out_valid & out_ready
module popcnt_stream #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 3,
  parameter int ACC_W = 16,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_parity,
  output logic             out_major,
  output logic [ACC_W-1:0] out_total,
  output logic             out_sat
);

  localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int NW = $clog2(N + 1);
  localparam logic [ACC_W:0] TOTAL_MAX = {1'b0, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic             started;
  logic [WIDTH-1:0] sreg;
  logic [NW-1:0]    chunk_idx;
  logic [CW-1:0]    pcnt;
  logic             acc_q;
  logic [CW-1:0]    chunk_ones;
  logic [CW-1:0]    pcnt_sum;
  logic             last_chunk;
  logic             update;
  logic             keep;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] total_nx;
  logic             sat_nx;

  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_ones = chunk_ones + CW'(sreg[i]);
    end
  end

  assign pcnt_sum   = pcnt + chunk_ones;
  assign last_chunk = (chunk_idx == NW'(N - 1));
  assign update     = (state == BUSY) && last_chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready is held low through reset and rises on the first edge after release.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = started;
        if (in_valid && started) state_nx = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      sreg       <= '0;
      chunk_idx  <= '0;
      pcnt       <= '0;
      acc_q      <= 1'b0;
      out_count  <= '0;
      out_parity <= 1'b0;
      out_major  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (state == IDLE && in_valid && started) begin
        sreg      <= in_data;
        acc_q     <= in_acc;
        pcnt      <= '0;
        chunk_idx <= '0;
      end else if (state == BUSY) begin
        sreg      <= sreg >> CHUNK;
        pcnt      <= pcnt_sum;
        chunk_idx <= chunk_idx + NW'(1);
        if (last_chunk) begin
          out_count  <= pcnt_sum;
          out_parity <= pcnt_sum[0];
          out_major  <= (pcnt_sum > CW'(WIDTH / 2));
        end
      end
    end
  end

  // A clear on the update edge wins over the old total, leaving just this word's count.
  always_comb begin
    keep     = acc_q && !clr;
    sum      = (keep ? {1'b0, out_total} : '0) + (ACC_W + 1)'(pcnt_sum);
    total_nx = out_total;
    sat_nx   = out_sat;
    if (update) begin
      total_nx = (sum > TOTAL_MAX) ? TOTAL_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
      sat_nx   = (keep && out_sat) || (sum > TOTAL_MAX);
    end else if (clr) begin
      total_nx = '0;
      sat_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_total <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_total <= total_nx;
      out_sat   <= sat_nx;
    end
  end

endmodule

// File: tb/tb_popcnt_stream.sv
// Bench for popcnt_stream: an 8-bit/3-chunk/4-bit-total instance and a 3-bit legacy
// instance, checked against a plain arithmetic model of count, majority and total.
module tb_popcnt_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel_v = 1'b0;
  logic       d_valid = 1'b0;
  logic [7:0] d_data = '0;
  logic       d_acc = 1'b0;
  logic       d_clr = 1'b0;
  logic       d_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_parity, a_out_major, a_out_sat;
  logic [3:0] a_out_count;
  logic [3:0] a_out_total;
  logic       b_in_ready, b_out_valid, b_out_parity, b_out_major, b_out_sat;
  logic [1:0] b_out_count;
  logic [7:0] b_out_total;

  popcnt_stream #(.WIDTH(8), .CHUNK(3), .ACC_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_valid & ~sel_v), .in_ready(a_in_ready), .in_data(d_data),
    .in_acc(d_acc), .clr(d_clr & ~sel_v),
    .out_valid(a_out_valid), .out_ready(d_ready & ~sel_v),
    .out_count(a_out_count), .out_parity(a_out_parity), .out_major(a_out_major),
    .out_total(a_out_total), .out_sat(a_out_sat)
  );

  popcnt_stream #(.WIDTH(3), .CHUNK(3), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_valid & sel_v), .in_ready(b_in_ready), .in_data(d_data[2:0]),
    .in_acc(d_acc), .clr(d_clr & sel_v),
    .out_valid(b_out_valid), .out_ready(d_ready & sel_v),
    .out_count(b_out_count), .out_parity(b_out_parity), .out_major(b_out_major),
    .out_total(b_out_total), .out_sat(b_out_sat)
  );

  logic       s_in_ready, s_out_valid, s_parity, s_major, s_sat;
  logic [3:0] s_count;
  logic [7:0] s_total;
  assign s_in_ready  = sel_v ? b_in_ready  : a_in_ready;
  assign s_out_valid = sel_v ? b_out_valid : a_out_valid;
  assign s_parity    = sel_v ? b_out_parity : a_out_parity;
  assign s_major     = sel_v ? b_out_major : a_out_major;
  assign s_sat       = sel_v ? b_out_sat : a_out_sat;
  assign s_count     = sel_v ? {2'b00, b_out_count} : a_out_count;
  assign s_total     = sel_v ? b_out_total : {4'h0, a_out_total};

  int errors = 0;
  int checks = 0;
  int m_total [2] = '{0, 0};
  bit m_sat [2] = '{0, 0};
  int m_max [2] = '{15, 255};
  int m_width [2] = '{8, 3};
  int m_n [2] = '{3, 1};

  task automatic send(input logic [7:0] data, input logic acc, input logic clr_upd);
    int  idx, cnt, e_cnt, lat, w;
    bit  e_maj;
    logic [7:0] masked;
    idx    = sel_v ? 1 : 0;
    w      = 0;
    masked = sel_v ? (data & 8'h07) : data;
    e_cnt  = $countones(masked);
    e_maj  = (e_cnt > m_width[idx] / 2);
    if (clr_upd) begin
      m_total[idx] = e_cnt; m_sat[idx] = 0;
    end else if (acc) begin
      if (m_total[idx] + e_cnt > m_max[idx]) begin
        m_total[idx] = m_max[idx]; m_sat[idx] = 1;
      end else m_total[idx] = m_total[idx] + e_cnt;
    end else begin
      m_total[idx] = e_cnt; m_sat[idx] = 0;
    end
    @(negedge clk);
    while (!s_in_ready && w < 20) begin
      @(negedge clk); w++;
    end
    checks++;
    if (!s_in_ready) begin
      errors++;
      $display("FAIL accept_wait in_ready=%0b required=1", s_in_ready);
      return;
    end
    d_valid = 1'b1; d_data = data; d_acc = acc;
    @(posedge clk); #1;
    d_valid = 1'b0;
    cnt = 1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready cycle=%0d got=%0b required=0", cnt, s_in_ready);
    end
    while (!s_out_valid && cnt < 40) begin
      if (clr_upd && cnt == m_n[idx]) d_clr = 1'b1;
      @(posedge clk); #1;
      d_clr = 1'b0;
      cnt++;
      checks++;
      if (s_in_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready cycle=%0d got=%0b required=0", cnt, s_in_ready);
      end
    end
    lat = cnt;
    checks++;
    if (lat != m_n[idx] + 1) begin
      errors++; $display("FAIL latency data=%h got=%0d required=%0d", data, lat, m_n[idx] + 1);
    end
    checks++;
    if (s_count !== 4'(e_cnt)) begin
      errors++; $display("FAIL count data=%h got=%0d required=%0d", data, s_count, e_cnt);
    end
    checks++;
    if (s_parity !== e_cnt[0]) begin
      errors++; $display("FAIL parity data=%h got=%0b required=%0b", data, s_parity, e_cnt[0]);
    end
    checks++;
    if (s_major !== e_maj) begin
      errors++; $display("FAIL major data=%h got=%0b required=%0b", data, s_major, e_maj);
    end
    checks++;
    if (s_total !== 8'(m_total[idx])) begin
      errors++; $display("FAIL total data=%h got=%0d required=%0d", data, s_total, m_total[idx]);
    end
    checks++;
    if (s_sat !== m_sat[idx]) begin
      errors++; $display("FAIL sat data=%h got=%0b required=%0b", data, s_sat, m_sat[idx]);
    end
  endtask

  task automatic take();
    @(negedge clk);
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL take out_valid=%0b in_ready=%0b required 0/1", s_out_valid, s_in_ready);
    end
  endtask

  task automatic clear_alone();
    @(negedge clk);
    d_clr = 1'b1;
    @(posedge clk); #1;
    d_clr = 1'b0;
    m_total[sel_v ? 1 : 0] = 0;
    m_sat[sel_v ? 1 : 0] = 0;
    checks++;
    if (s_total !== 8'h00 || s_sat !== 1'b0) begin
      errors++; $display("FAIL clr_alone total=%0d sat=%0b required 0/0", s_total, s_sat);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs a_rdy=%0b a_vld=%0b b_rdy=%0b b_vld=%0b required 0", a_in_ready, a_out_valid, b_in_ready, b_out_valid);
    end
    checks++;
    if ({a_out_count, a_out_parity, a_out_major, a_out_total, a_out_sat} !== '0) begin
      errors++; $display("FAIL reset_out count=%0d total=%0d required 0", a_out_count, a_out_total);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release a_rdy=%0b b_rdy=%0b required 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    sel_v = 1'b0;
    send(8'hB5, 1'b0, 1'b0);
    take();
  endtask

  task automatic test_majority();
    sel_v = 1'b0;
    send(8'h0F, 1'b0, 1'b0); take();
    send(8'h1F, 1'b0, 1'b0); take();
  endtask

  task automatic test_saturation();
    sel_v = 1'b0;
    send(8'hFF, 1'b0, 1'b0); take();
    send(8'hFF, 1'b1, 1'b0); take();
    send(8'h01, 1'b1, 1'b0); take();
    clear_alone();
  endtask

  task automatic test_backpressure();
    logic [3:0] h_count;
    logic [7:0] h_total;
    sel_v = 1'b0;
    send(8'h6C, 1'b1, 1'b0);
    h_count = s_count;
    h_total = s_total;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d_valid = (i % 2 == 0);
      d_data  = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (s_out_valid !== 1'b1 || s_count !== h_count || s_total !== h_total) begin
        errors++;
        $display("FAIL backpressure cycle=%0d vld=%0b count=%0d total=%0d required 1/%0d/%0d",
                 i, s_out_valid, s_count, s_total, h_count, h_total);
      end
    end
    d_valid = 1'b0;
    take();
  endtask

  task automatic test_reset_mid();
    sel_v = 1'b0;
    @(negedge clk);
    d_valid = 1'b1; d_data = 8'hB5; d_acc = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_count, a_out_parity, a_out_major, a_out_total, a_out_sat, a_out_valid, a_in_ready} !== '0
        || b_out_total !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid count=%0d total=%0d vld=%0b rdy=%0b required 0", a_out_count, a_out_total, a_out_valid, a_in_ready);
    end
    m_total = '{0, 0};
    m_sat   = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release rdy=%0b vld=%0b required 1/0", a_in_ready, a_out_valid);
    end
    send(8'hB5, 1'b0, 1'b0);
    take();
  endtask

  task automatic test_random();
    sel_v = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) clear_alone();
      send(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      take();
    end
  endtask

  task automatic test_legacy();
    logic [2:0] v;
    sel_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      send({5'b0, v}, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (s_major !== ((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])) || s_parity !== ^v) begin
        errors++; $display("FAIL legacy v=%0d maj=%0b par=%0b", v, s_major, s_parity);
      end
      take();
    end
    send(8'h07, 1'b1, 1'b0); take();
    send(8'h07, 1'b1, 1'b0); take();
    send(8'h05, 1'b1, 1'b1); take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_majority();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_legacy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
